// File: rtl/bp_be_fe_cmd_gen_pkg.sv
// FE/BE command and message types shared by the command generator.
// Widths derive from the processor configuration selector.
package bp_be_fe_cmd_gen_pkg;

    typedef enum logic [0:0] {
        e_bp_default_cfg = 1'b0
    } bp_params_e;

    localparam int vaddr_width_gp         = 39;
    localparam int instr_width_gp         = 32;
    localparam int operand_width_gp       = 32;
    localparam int fe_cmd_opcode_width_gp = 4;

    typedef enum logic [fe_cmd_opcode_width_gp-1:0] {
        e_op_state_reset          = 4'd0,
        e_op_pc_redirection       = 4'd1,
        e_op_icache_fill_response = 4'd2,
        e_op_icache_fence         = 4'd3,
        e_op_itlb_fill_response   = 4'd4,
        e_op_itlb_fence           = 4'd5,
        e_op_attaboy              = 4'd6,
        e_op_wait                 = 4'd7
    } bp_fe_command_queue_opcode_e;

    typedef enum logic [1:0] {
        e_fe_fetch     = 2'd0,
        e_fe_exception = 2'd1
    } bp_fe_queue_type_e;

    // Opcode must stay the most significant field: the generator
    // decodes it straight from the packed vector.
    typedef struct packed {
        bp_fe_command_queue_opcode_e   opcode;
        logic [vaddr_width_gp-1:0]     vaddr;
        logic [operand_width_gp-1:0]   operands;
    } bp_fe_cmd_s;

    typedef struct packed {
        bp_fe_queue_type_e             msg_type;
        logic [vaddr_width_gp-1:0]     pc;
        logic [instr_width_gp-1:0]     instr;
    } bp_fe_queue_s;

    function automatic int fe_cmd_width_f(bp_params_e cfg);
        case (cfg)
            e_bp_default_cfg: return $bits(bp_fe_cmd_s);
            default:          return $bits(bp_fe_cmd_s);
        endcase
    endfunction

    function automatic int fe_queue_width_f(bp_params_e cfg);
        case (cfg)
            e_bp_default_cfg: return $bits(bp_fe_queue_s);
            default:          return $bits(bp_fe_queue_s);
        endcase
    endfunction

endpackage

// File: rtl/bsg_fifo_1r1w_small.sv
// Small in-order FIFO with valid/ready input and valid/yumi output.
// Reset clears all entries; callers use it as a synchronous flush.
module bsg_fifo_1r1w_small #(
    parameter int width_p = 8,
    parameter int els_p   = 2
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               v_i,
    output logic               ready_o,
    input  logic [width_p-1:0] data_i,
    output logic               v_o,
    output logic [width_p-1:0] data_o,
    input  logic               yumi_i
);

    localparam int ptr_w = (els_p > 1) ? $clog2(els_p) : 1;
    localparam int cnt_w = $clog2(els_p + 1);

    logic [width_p-1:0] mem_r [els_p];
    logic [ptr_w-1:0]   wptr_r;
    logic [ptr_w-1:0]   rptr_r;
    logic [cnt_w-1:0]   count_r;
    logic               push;
    logic               pop;

    assign ready_o = (count_r != cnt_w'(els_p));
    assign v_o     = (count_r != '0);
    assign data_o  = mem_r[rptr_r];
    assign push    = v_i & ready_o;
    assign pop     = yumi_i & v_o;

    // Pointer and occupancy bookkeeping; clear wins over push and pop.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wptr_r  <= '0;
            rptr_r  <= '0;
            count_r <= '0;
        end else begin
            if (push) begin
                wptr_r <= (wptr_r == ptr_w'(els_p - 1))
                        ? '0 : wptr_r + ptr_w'(1);
            end
            if (pop) begin
                rptr_r <= (rptr_r == ptr_w'(els_p - 1))
                        ? '0 : rptr_r + ptr_w'(1);
            end
            count_r <= count_r + cnt_w'(push) - cnt_w'(pop);
        end
    end

    // Storage needs no reset; occupancy decides what is visible.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_r[wptr_r] <= data_i;
        end
    end

endmodule

// File: rtl/bp_be_fe_cmd_gen.sv
// Buffers BE->FE commands and filters FE->BE messages that were
// fetched down a path invalidated by an outstanding command.
module bp_be_fe_cmd_gen
    import bp_be_fe_cmd_gen_pkg::*;
#(
    parameter bp_params_e bp_params_p = e_bp_default_cfg,
    localparam int fe_cmd_width_lp   = fe_cmd_width_f(bp_params_p),
    localparam int fe_queue_width_lp = fe_queue_width_f(bp_params_p)
) (
    input  logic                         clk_i,
    input  logic                         reset_i,

    input  logic [fe_cmd_width_lp-1:0]   cmd_i,
    input  logic                         cmd_v_i,
    output logic                         cmd_ready_o,

    output logic [fe_cmd_width_lp-1:0]   fe_cmd_o,
    output logic                         fe_cmd_v_o,
    input  logic                         fe_cmd_yumi_i,

    input  logic [fe_queue_width_lp-1:0] fe_queue_i,
    input  logic                         fe_queue_v_i,
    output logic                         fe_queue_ready_o,

    output logic [fe_queue_width_lp-1:0] fetch_o,
    output logic                         fetch_v_o,
    input  logic                         fetch_yumi_i,

    output logic [15:0]                  attaboy_drop_cnt_o
);

    localparam logic [0:0] e_ready = 1'b0;
    localparam logic [0:0] e_stale = 1'b1;

    localparam int op_w = fe_cmd_opcode_width_gp;

    logic [0:0]      state_r;
    logic [0:0]      state_n;
    logic [1:0]      stale_r;
    logic [1:0]      stale_n;
    logic [15:0]     drop_cnt_r;

    logic [op_w-1:0] cmd_op;
    logic [op_w-1:0] head_op;
    logic            cmd_is_attaboy;
    logic            head_is_attaboy;

    logic            cmd_fifo_ready;
    logic            cmd_fifo_v;
    logic            fetch_fifo_ready;
    logic            fetch_fifo_v;

    logic            cmd_enq;
    logic            cmd_deq;
    logic            nab_enq;
    logic            nab_deq;
    logic            attaboy_drop;
    logic            fetch_flush;
    logic            fetch_discard;
    logic            fetch_push;
    logic            fetch_pop;

    assign cmd_op          = cmd_i[fe_cmd_width_lp-1 -: op_w];
    assign head_op         = fe_cmd_o[fe_cmd_width_lp-1 -: op_w];
    assign cmd_is_attaboy  = (cmd_op == e_op_attaboy);
    assign head_is_attaboy = (head_op == e_op_attaboy);

    // Ready and valid are held low while reset is asserted so nothing
    // is accepted or presented before the FIFOs are known empty.
    assign cmd_ready_o      = cmd_fifo_ready & ~reset_i;
    assign fe_cmd_v_o       = cmd_fifo_v & ~reset_i;
    assign fe_queue_ready_o = fetch_fifo_ready & ~reset_i;
    assign fetch_v_o        = fetch_fifo_v & ~reset_i;

    // Attaboys share the not-full condition, so they never stall BE;
    // when they cannot enter they are counted and forgotten.
    assign cmd_enq      = cmd_v_i & cmd_ready_o;
    assign nab_enq      = cmd_enq & ~cmd_is_attaboy;
    assign attaboy_drop = cmd_v_i & cmd_is_attaboy
                        & ~cmd_ready_o & ~reset_i;

    assign cmd_deq = fe_cmd_yumi_i & fe_cmd_v_o;
    assign nab_deq = cmd_deq & ~head_is_attaboy;

    // A new redirect-class command makes every buffered message stale.
    // Messages keep being dropped until FE has taken the last such
    // command, including the cycle in which it takes it.
    assign fetch_flush   = nab_enq;
    assign fetch_discard = (state_r == e_stale) | nab_deq | nab_enq;
    assign fetch_push    = fe_queue_v_i & fe_queue_ready_o
                         & ~fetch_discard;
    assign fetch_pop     = fetch_yumi_i & fetch_v_o;

    assign attaboy_drop_cnt_o = drop_cnt_r;

    bsg_fifo_1r1w_small #(
        .width_p (fe_cmd_width_lp),
        .els_p   (2)
    ) cmd_fifo (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .v_i     (cmd_enq),
        .ready_o (cmd_fifo_ready),
        .data_i  (cmd_i),
        .v_o     (cmd_fifo_v),
        .data_o  (fe_cmd_o),
        .yumi_i  (cmd_deq)
    );

    bsg_fifo_1r1w_small #(
        .width_p (fe_queue_width_lp),
        .els_p   (2)
    ) fetch_fifo (
        .clk_i   (clk_i),
        .reset_i (reset_i | fetch_flush),
        .v_i     (fetch_push),
        .ready_o (fetch_fifo_ready),
        .data_i  (fe_queue_i),
        .v_o     (fetch_fifo_v),
        .data_o  (fetch_o),
        .yumi_i  (fetch_pop)
    );

    // Next stale count and state; enqueue and yumi together cancel.
    always_comb begin
        stale_n = stale_r;
        case ({nab_enq, nab_deq})
            2'b10:   stale_n = stale_r + 2'd1;
            2'b01:   stale_n = stale_r - 2'd1;
            default: stale_n = stale_r;
        endcase
        state_n = (stale_n != 2'd0) ? e_stale : e_ready;
    end

    // Stale tracking registers.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            stale_r <= 2'd0;
            state_r <= e_ready;
        end else begin
            stale_r <= stale_n;
            state_r <= state_n;
        end
    end

    // Saturating count of attaboys that found the queue full.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            drop_cnt_r <= 16'd0;
        end else if (attaboy_drop && (drop_cnt_r != 16'hFFFF)) begin
            drop_cnt_r <= drop_cnt_r + 16'd1;
        end
    end

endmodule

// File: tb/tb_bp_be_fe_cmd_gen.sv
// Directed scoreboard bench for the BE->FE command generator.
module tb_bp_be_fe_cmd_gen;
    import bp_be_fe_cmd_gen_pkg::*;

    localparam int cw = $bits(bp_fe_cmd_s);
    localparam int qw = $bits(bp_fe_queue_s);

    logic          clk = 1'b0;
    logic          reset_i;
    bp_fe_cmd_s    cmd;
    logic          cmd_v_i;
    logic          cmd_ready_o;
    logic [cw-1:0] fe_cmd_o;
    logic          fe_cmd_v_o;
    logic          fe_cmd_yumi_i;
    bp_fe_queue_s  fe_queue;
    logic          fe_queue_v_i;
    logic          fe_queue_ready_o;
    logic [qw-1:0] fetch_o;
    logic          fetch_v_o;
    logic          fetch_yumi_i;
    logic [15:0]   drop_cnt;

    int checks   = 0;
    int failures = 0;

    bp_fe_cmd_s   cmd_q[$];
    bp_fe_queue_s fetch_q[$];

    always #5 clk = ~clk;

    bp_be_fe_cmd_gen dut (
        .clk_i              (clk),
        .reset_i            (reset_i),
        .cmd_i              (cmd),
        .cmd_v_i            (cmd_v_i),
        .cmd_ready_o        (cmd_ready_o),
        .fe_cmd_o           (fe_cmd_o),
        .fe_cmd_v_o         (fe_cmd_v_o),
        .fe_cmd_yumi_i      (fe_cmd_yumi_i),
        .fe_queue_i         (fe_queue),
        .fe_queue_v_i       (fe_queue_v_i),
        .fe_queue_ready_o   (fe_queue_ready_o),
        .fetch_o            (fetch_o),
        .fetch_v_o          (fetch_v_o),
        .fetch_yumi_i       (fetch_yumi_i),
        .attaboy_drop_cnt_o (drop_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag,
                       input logic [127:0] obs,
                       input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bp_fe_cmd_s mk_cmd(
        bp_fe_command_queue_opcode_e op, logic [38:0] va);
        bp_fe_cmd_s c;
        c.opcode   = op;
        c.vaddr    = va;
        c.operands = 32'hC0DE_0000 | 32'(va[15:0]);
        return c;
    endfunction

    function automatic bp_fe_queue_s mk_msg(
        bp_fe_queue_type_e t, logic [38:0] pc);
        bp_fe_queue_s m;
        m.msg_type = t;
        m.pc       = pc;
        m.instr    = 32'h0000_0013 ^ 32'(pc[15:0]);
        return m;
    endfunction

    // Drive a command for one cycle; expected when it will enqueue.
    task automatic send_cmd(input bp_fe_cmd_s c, input bit stored);
        cmd     = c;
        cmd_v_i = 1'b1;
        if (stored) cmd_q.push_back(c);
    endtask

    task automatic send_msg(input bp_fe_queue_s m, input bit stored);
        fe_queue     = m;
        fe_queue_v_i = 1'b1;
        if (stored) fetch_q.push_back(m);
    endtask

    // Yumi the command head this cycle and score it.
    task automatic take_cmd(input string tag);
        fe_cmd_yumi_i = 1'b1;
        chk({tag, "_v"}, 128'(fe_cmd_v_o), 128'(1'b1));
        if (cmd_q.size() == 0) begin
            checks++;
            failures++;
            $error("FAIL %s_sb observed=empty expected=entry", tag);
        end else begin
            chk(tag, 128'(fe_cmd_o), 128'(cmd_q.pop_front()));
        end
    endtask

    task automatic take_msg(input string tag);
        fetch_yumi_i = 1'b1;
        chk({tag, "_v"}, 128'(fetch_v_o), 128'(1'b1));
        if (fetch_q.size() == 0) begin
            checks++;
            failures++;
            $error("FAIL %s_sb observed=empty expected=entry", tag);
        end else begin
            chk(tag, 128'(fetch_o), 128'(fetch_q.pop_front()));
        end
    endtask

    task automatic idle();
        cmd_v_i       = 1'b0;
        fe_cmd_yumi_i = 1'b0;
        fe_queue_v_i  = 1'b0;
        fetch_yumi_i  = 1'b0;
    endtask

    initial begin
        reset_i  = 1'b1;
        cmd      = '0;
        fe_queue = '0;
        idle();

        // Reset values
        tick();
        tick();
        chk("rst_cmd_ready", 128'(cmd_ready_o), 128'(1'b0));
        chk("rst_q_ready", 128'(fe_queue_ready_o), 128'(1'b0));
        chk("rst_cmd_v", 128'(fe_cmd_v_o), 128'(1'b0));
        chk("rst_fetch_v", 128'(fetch_v_o), 128'(1'b0));
        chk("rst_drop", 128'(drop_cnt), 128'(16'd0));
        reset_i = 1'b0;
        tick();
        chk("post_cmd_ready", 128'(cmd_ready_o), 128'(1'b1));
        chk("post_q_ready", 128'(fe_queue_ready_o), 128'(1'b1));
        chk("post_stale", 128'(dut.stale_r), 128'(2'd0));

        // Redirect appears one cycle later, not combinationally
        send_cmd(mk_cmd(e_op_pc_redirection, 39'h0_8000_0000), 1'b1);
        chk("redir_comb_v", 128'(fe_cmd_v_o), 128'(1'b0));
        tick();
        idle();
        chk("redir_vaddr", 128'(fe_cmd_o[cw-5 -: 39]),
            128'(39'h0_8000_0000));
        chk("redir_stale", 128'(dut.stale_r), 128'(2'd1));
        chk("redir_state", 128'(dut.state_r), 128'(1'b1));
        take_cmd("redir_head");
        tick();
        idle();
        chk("redir_done_v", 128'(fe_cmd_v_o), 128'(1'b0));
        chk("redir_done_stale", 128'(dut.stale_r), 128'(2'd0));

        // Two fetches buffered, then flushed by a redirect
        send_msg(mk_msg(e_fe_fetch, 39'h200), 1'b1);
        tick();
        send_msg(mk_msg(e_fe_fetch, 39'h204), 1'b1);
        tick();
        idle();
        chk("fetch_full", 128'(fe_queue_ready_o), 128'(1'b0));
        chk("fetch_head", 128'(fetch_o), 128'(fetch_q[0]));
        send_cmd(mk_cmd(e_op_pc_redirection, 39'h0_8000_0000), 1'b1);
        tick();
        idle();
        fetch_q.delete();
        chk("flush_v", 128'(fetch_v_o), 128'(1'b0));
        chk("flush_ready", 128'(fe_queue_ready_o), 128'(1'b1));
        send_msg(mk_msg(e_fe_fetch, 39'h100), 1'b0);
        tick();
        idle();
        chk("stale_drop_v", 128'(fetch_v_o), 128'(1'b0));
        take_cmd("flush_redir");
        send_msg(mk_msg(e_fe_fetch, 39'h104), 1'b0);
        tick();
        idle();
        chk("yumi_drop_v", 128'(fetch_v_o), 128'(1'b0));
        chk("yumi_stale", 128'(dut.stale_r), 128'(2'd0));
        send_msg(mk_msg(e_fe_fetch, 39'h0_8000_0000), 1'b1);
        tick();
        idle();
        take_msg("new_path_fetch");
        tick();
        idle();

        // Exceptions are kept in order with fetches
        send_msg(mk_msg(e_fe_exception, 39'h300), 1'b1);
        tick();
        send_msg(mk_msg(e_fe_fetch, 39'h304), 1'b1);
        tick();
        idle();
        take_msg("exc_first");
        tick();
        idle();
        take_msg("exc_second");
        tick();
        idle();
        chk("exc_empty", 128'(fetch_v_o), 128'(1'b0));

        // Full queue drops attaboys and counts them
        send_cmd(mk_cmd(e_op_pc_redirection, 39'h1000), 1'b1);
        tick();
        send_cmd(mk_cmd(e_op_pc_redirection, 39'h2000), 1'b1);
        tick();
        idle();
        chk("cmd_full", 128'(cmd_ready_o), 128'(1'b0));
        chk("stale_two", 128'(dut.stale_r), 128'(2'd2));
        for (int i = 0; i < 3; i++) begin
            send_cmd(mk_cmd(e_op_attaboy, 39'(i)), 1'b0);
            tick();
        end
        idle();
        chk("drop_cnt", 128'(drop_cnt), 128'(16'd3));
        chk("full_hold", 128'(cmd_ready_o), 128'(1'b0));

        // Enqueue and yumi of redirects in one cycle
        take_cmd("pop_1000");
        tick();
        idle();
        chk("stale_one", 128'(dut.stale_r), 128'(2'd1));
        send_cmd(mk_cmd(e_op_pc_redirection, 39'h3000), 1'b1);
        take_cmd("pop_2000");
        tick();
        idle();
        chk("both_stale", 128'(dut.stale_r), 128'(2'd1));
        chk("both_state", 128'(dut.state_r), 128'(1'b1));

        // Attaboy with room is queued but does not make fetches stale
        send_cmd(mk_cmd(e_op_attaboy, 39'h44), 1'b1);
        tick();
        idle();
        chk("ab_stale", 128'(dut.stale_r), 128'(2'd1));
        chk("ab_full", 128'(cmd_ready_o), 128'(1'b0));
        take_cmd("pop_3000");
        tick();
        idle();
        chk("ready_state", 128'(dut.state_r), 128'(1'b0));
        take_cmd("pop_ab");
        tick();
        idle();
        chk("ab_pop_stale", 128'(dut.stale_r), 128'(2'd0));
        chk("ab_pop_v", 128'(fe_cmd_v_o), 128'(1'b0));

        // Fill both queues, then reset mid-operation
        send_cmd(mk_cmd(e_op_attaboy, 39'h51), 1'b1);
        send_msg(mk_msg(e_fe_fetch, 39'h500), 1'b1);
        tick();
        send_cmd(mk_cmd(e_op_attaboy, 39'h52), 1'b1);
        send_msg(mk_msg(e_fe_fetch, 39'h504), 1'b1);
        tick();
        idle();
        chk("fill_cmd_v", 128'(fe_cmd_v_o), 128'(1'b1));
        chk("fill_fetch", 128'(fetch_o), 128'(fetch_q[0]));
        chk("fill_q_ready", 128'(fe_queue_ready_o), 128'(1'b0));
        reset_i = 1'b1;
        tick();
        chk("mid_rst_ready", 128'(cmd_ready_o), 128'(1'b0));
        reset_i = 1'b0;
        cmd_q.delete();
        fetch_q.delete();
        tick();
        chk("rel_cmd_v", 128'(fe_cmd_v_o), 128'(1'b0));
        chk("rel_fetch_v", 128'(fetch_v_o), 128'(1'b0));
        chk("rel_drop", 128'(drop_cnt), 128'(16'd0));
        chk("rel_stale", 128'(dut.stale_r), 128'(2'd0));
        chk("rel_cmd_ready", 128'(cmd_ready_o), 128'(1'b1));
        chk("rel_q_ready", 128'(fe_queue_ready_o), 128'(1'b1));

        // First command after reset is the one presented
        send_cmd(mk_cmd(e_op_pc_redirection, 39'h4000), 1'b1);
        tick();
        idle();
        take_cmd("after_rst");
        tick();
        idle();
        chk("end_cmd_v", 128'(fe_cmd_v_o), 128'(1'b0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
